fir_sequencer: RTL and testbench

Control sequencer for the FIR engine. It starts on `ap_start` from the AXI-Lite block and clears the data RAM. It then accepts one input sample per AXI-Stream beat, stores it in a circular data RAM, and steps the tap/data RAM addresses through one multiply-accumulate pass per sample. It drives the output stream handshake and returns `ap_idle`/`ap_done`, and it supplies `fir_raddr` to the AXI-Lite tap-RAM address mux during calculation.

---
 rtl/fir_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_fir_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// Control sequencer for the FIR engine: data-RAM clear, sample ingest, MAC address stepping, output handshake.
// Optional feature macro: FIR_SEQ_CLEAR_EN (defined = data RAM is cleared at the start of every run).
module fir_sequencer #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [pDATA_WIDTH-1:0] data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [3:0]             fir_raddr,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic [2:0]             state_o,
  output logic [3:0]             counter
);

  localparam logic [4:0] TAPS      = 5'(Tape_Num);
  localparam logic [3:0] WPTR_LAST = 4'(Tape_Num - 1);
`ifdef FIR_SEQ_CLEAR_EN
  localparam logic [4:0] TAPS_M1   = 5'(Tape_Num - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_MAC    = 3'd2,
    S_WAIT_X = 3'd3,
    S_OUT    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  // 5 bits so MAC can reach Tape_Num=16; the status port shows the low 4 bits.
  logic [4:0]             cnt;
  logic [3:0]             wptr;
  logic [pDATA_WIDTH-1:0] nsamp;
  logic [pDATA_WIDTH-1:0] len_q;
  logic                   start_q;
  logic                   mac_en_q;
  logic                   start_rise;
  logic                   ss_hs;
  logic                   sm_hs;
  logic                   addr_issue;
  logic                   last_flag;
  logic [4:0]             wptr_ext;
  logic [4:0]             rd_idx;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [4:0] idx);
    word_addr      = '0;
    word_addr[6:2] = idx;
  endfunction

  assign start_rise = ap_start & ~start_q;
  assign wptr_ext   = {1'b0, wptr};
  assign last_flag  = (nsamp == len_q);
  assign data_EN    = 1'b1;
  assign mac_en     = mac_en_q;
  assign state_o    = state;
  assign counter    = cnt[3:0];

  // Circular read index (wptr - k) mod Tape_Num, wrap-add instead of a divider.
  always_comb begin
    rd_idx = '0;
    if (wptr_ext >= cnt) rd_idx = wptr_ext - cnt;
    else                 rd_idx = wptr_ext + TAPS - cnt;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ap_idle    = 1'b0;
    ap_done    = 1'b0;
    ss_tready  = 1'b0;
    sm_tvalid  = 1'b0;
    sm_tlast   = 1'b0;
    data_WE    = 4'h0;
    data_A     = '0;
    data_Di    = '0;
    fir_raddr  = 4'd0;
    mac_clr    = 1'b0;
    addr_issue = 1'b0;
    ss_hs      = 1'b0;
    sm_hs      = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (start_rise) begin
`ifdef FIR_SEQ_CLEAR_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = (data_length == '0) ? S_DONE : S_WAIT_X;
`endif
        end
      end
`ifdef FIR_SEQ_CLEAR_EN
      S_CLEAR: begin
        data_WE = 4'hF;
        data_A  = word_addr(cnt);
        if (cnt == TAPS_M1) state_nxt = (len_q == '0) ? S_DONE : S_WAIT_X;
      end
`endif
      S_WAIT_X: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          ss_hs     = 1'b1;
          data_WE   = 4'hF;
          data_A    = word_addr(wptr_ext);
          data_Di   = ss_tdata;
          mac_clr   = 1'b1;
          state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        if (cnt < TAPS) begin
          addr_issue = 1'b1;
          fir_raddr  = cnt[3:0];
          data_A     = word_addr(rd_idx);
        end else begin
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = last_flag;
        if (sm_tready) begin
          sm_hs     = 1'b1;
          state_nxt = last_flag ? S_DONE : S_WAIT_X;
        end
      end
      S_DONE: begin
        ap_idle   = 1'b1;
        ap_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      cnt      <= '0;
      wptr     <= '0;
      nsamp    <= '0;
      len_q    <= '0;
      start_q  <= 1'b0;
      mac_en_q <= 1'b0;
    end else begin
      start_q  <= ap_start;
      // Delayed by one cycle so the enable lines up with the RAM read data.
      mac_en_q <= addr_issue;
      case (state)
        S_IDLE: begin
          cnt   <= '0;
          wptr  <= '0;
          nsamp <= '0;
          if (start_rise) len_q <= data_length;
        end
`ifdef FIR_SEQ_CLEAR_EN
        S_CLEAR: cnt <= (cnt == TAPS_M1) ? 5'd0 : cnt + 5'd1;
`endif
        S_WAIT_X: begin
          if (ss_hs) begin
            nsamp <= nsamp + pDATA_WIDTH'(1);
            cnt   <= '0;
          end
        end
        S_MAC: cnt <= (cnt == TAPS) ? 5'd0 : cnt + 5'd1;
        S_OUT: begin
          if (sm_hs) wptr <= (wptr == WPTR_LAST) ? 4'd0 : wptr + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer: spec-level model of write pointer, sample count and MAC address order.
// Builds with or without FIR_SEQ_CLEAR_EN; the clear-pass checks follow the macro.
module tb_fir_sequencer;
  localparam int N  = 11;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n;
  logic          ap_start;
  logic [DW-1:0] data_length;
  logic          ap_idle, ap_done;
  logic          ss_tvalid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tready;
  logic          sm_tvalid, sm_tready, sm_tlast;
  logic [3:0]    data_WE;
  logic          data_EN;
  logic [AW-1:0] data_A;
  logic [DW-1:0] data_Di;
  logic [3:0]    fir_raddr;
  logic          mac_clr, mac_en;
  logic [2:0]    state_o;
  logic [3:0]    counter;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  int m_wptr, m_nsamp, m_len;

  always #5 axis_clk = ~axis_clk;

  fir_sequencer #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(N)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
    .ss_tready(ss_tready), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .data_WE(data_WE), .data_EN(data_EN), .data_A(data_A), .data_Di(data_Di),
    .fir_raddr(fir_raddr), .mac_clr(mac_clr), .mac_en(mac_en), .state_o(state_o), .counter(counter)
  );

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_reset();
    axis_rst_n = 1'b0; ap_start = 1'b0; data_length = '0;
    ss_tvalid = 1'b0; ss_tdata = '0; sm_tready = 1'b0;
    repeat (3) @(posedge axis_clk);
    #1;
    checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%0h exp=1", ap_idle); end
    checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0h exp=0", ap_done); end
    checks++; if (ss_tready !== 1'b0) begin failures++; $display("FAIL rst_ss_tready got=%0h exp=0", ss_tready); end
    checks++; if (sm_tvalid !== 1'b0) begin failures++; $display("FAIL rst_sm_tvalid got=%0h exp=0", sm_tvalid); end
    checks++; if (data_WE !== 4'h0) begin failures++; $display("FAIL rst_we got=%0h exp=0", data_WE); end
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    checks++; if (mac_en !== 1'b0) begin failures++; $display("FAIL rst_mac_en got=%0h exp=0", mac_en); end
    checks++; if (data_EN !== 1'b1) begin failures++; $display("FAIL rst_en got=%0h exp=1", data_EN); end
    axis_rst_n = 1'b1;
    step();
  endtask

  task automatic start_run(input int len, input bit hold);
    int exp_st;
    data_length = DW'(len);
    ap_start = 1'b1;
    #1;
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL start_idle got=%0d exp=0", state_o); end
    step();
    if (!hold) ap_start = 1'b0;
    m_len = len; m_wptr = 0; m_nsamp = 0;
`ifdef FIR_SEQ_CLEAR_EN
    for (int i = 0; i < N; i++) begin
      data_length = $urandom;
      checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL clr_state i=%0d got=%0d exp=1", i, state_o); end
      checks++; if (data_WE !== 4'hF) begin failures++; $display("FAIL clr_we i=%0d got=%0h exp=f", i, data_WE); end
      checks++; if (data_A !== AW'(i * 4)) begin failures++; $display("FAIL clr_addr i=%0d got=%0h exp=%0h", i, data_A, i * 4); end
      checks++; if (data_Di !== '0) begin failures++; $display("FAIL clr_di i=%0d got=%0h exp=0", i, data_Di); end
      checks++; if (ss_tready !== 1'b0) begin failures++; $display("FAIL clr_ss_tready i=%0d got=%0h exp=0", i, ss_tready); end
      step();
    end
`endif
    exp_st = (len == 0) ? 5 : 3;
    checks++; if (state_o !== 3'(exp_st)) begin failures++; $display("FAIL run_entry got=%0d exp=%0d", state_o, exp_st); end
    checks++; if (ss_tready !== (len != 0)) begin failures++; $display("FAIL entry_ss_tready got=%0h exp=%0h", ss_tready, len != 0); end
  endtask

  task automatic send_sample(input int bp, input int gaps);
    logic [DW-1:0] d;
    logic          last_exp, en_exp;
    int            a_exp, en_cnt, st_exp;
    for (int g = 0; g < gaps; g++) begin
      data_length = $urandom;
      checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL wait_state got=%0d exp=3", state_o); end
      checks++; if (data_WE !== 4'h0) begin failures++; $display("FAIL wait_we got=%0h exp=0", data_WE); end
      step();
    end
    d = $urandom;
    exp_q.push_back(d);
    ss_tvalid = 1'b1; ss_tdata = d;
    #1;
    checks++; if (ss_tready !== 1'b1) begin failures++; $display("FAIL in_ready got=%0h exp=1", ss_tready); end
    checks++; if (data_WE !== 4'hF) begin failures++; $display("FAIL in_we got=%0h exp=f", data_WE); end
    checks++; if (data_A !== AW'(m_wptr * 4)) begin failures++; $display("FAIL in_addr got=%0h exp=%0h", data_A, m_wptr * 4); end
    checks++; if (data_Di !== exp_q.pop_front()) begin failures++; $display("FAIL in_data got=%0h exp=%0h", data_Di, d); end
    checks++; if (mac_clr !== 1'b1) begin failures++; $display("FAIL in_mac_clr got=%0h exp=1", mac_clr); end
    step();
    ss_tvalid = 1'b0; ss_tdata = $urandom;
    m_nsamp++;
    last_exp = (m_nsamp == m_len);
    en_cnt = 0;
    for (int i = 0; i <= N; i++) begin
      en_exp = (i >= 1);
      checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL mac_state i=%0d got=%0d exp=2", i, state_o); end
      checks++; if (sm_tvalid !== 1'b0) begin failures++; $display("FAIL mac_tvalid i=%0d got=%0h exp=0", i, sm_tvalid); end
      checks++; if (counter !== 4'(i)) begin failures++; $display("FAIL mac_cnt got=%0d exp=%0d", counter, i); end
      checks++; if (mac_en !== en_exp) begin failures++; $display("FAIL mac_en i=%0d got=%0h exp=%0h", i, mac_en, en_exp); end
      if (i < N) begin
        a_exp = ((m_wptr - i + N) % N) * 4;
        checks++; if (fir_raddr !== 4'(i)) begin failures++; $display("FAIL mac_raddr got=%0d exp=%0d", fir_raddr, i); end
        checks++; if (data_A !== AW'(a_exp)) begin failures++; $display("FAIL mac_addr i=%0d got=%0h exp=%0h", i, data_A, a_exp); end
      end
      if (mac_en === 1'b1) en_cnt++;
      step();
    end
    checks++; if (en_cnt != N) begin failures++; $display("FAIL mac_en_count got=%0d exp=%0d", en_cnt, N); end
    checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL out_state got=%0d exp=4", state_o); end
    checks++; if (sm_tvalid !== 1'b1) begin failures++; $display("FAIL out_latency got=%0h exp=1", sm_tvalid); end
    checks++; if (mac_en !== 1'b0) begin failures++; $display("FAIL out_mac_en got=%0h exp=0", mac_en); end
    for (int b = 0; b < bp; b++) begin
      ss_tvalid = 1'($urandom_range(0, 1));
      #1;
      checks++; if (sm_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid got=%0h exp=1", sm_tvalid); end
      checks++; if (sm_tlast !== last_exp) begin failures++; $display("FAIL bp_tlast got=%0h exp=%0h", sm_tlast, last_exp); end
      checks++; if (ss_tready !== 1'b0) begin failures++; $display("FAIL bp_ss_tready got=%0h exp=0", ss_tready); end
      checks++; if (data_WE !== 4'h0) begin failures++; $display("FAIL bp_we got=%0h exp=0", data_WE); end
      step();
    end
    ss_tvalid = 1'b0;
    sm_tready = 1'b1;
    #1;
    checks++; if (sm_tlast !== last_exp) begin failures++; $display("FAIL out_tlast got=%0h exp=%0h", sm_tlast, last_exp); end
    step();
    sm_tready = 1'b0;
    m_wptr = (m_wptr + 1) % N;
    st_exp = last_exp ? 5 : 3;
    checks++; if (state_o !== 3'(st_exp)) begin failures++; $display("FAIL out_next got=%0d exp=%0d", state_o, st_exp); end
  endtask

  task automatic end_run();
    checks++; if (ap_done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%0h exp=1", ap_done); end
    checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL done_idle got=%0h exp=1", ap_idle); end
    step();
    checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL done_width got=%0h exp=0", ap_done); end
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL back_idle got=%0d exp=0", state_o); end
    checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL back_ap_idle got=%0h exp=1", ap_idle); end
  endtask

  task automatic test_run_backpressure();
    start_run(3, 1'b0);
    for (int s = 0; s < 3; s++) send_sample((s == 2) ? 5 : $urandom_range(0, 3), $urandom_range(0, 2));
    end_run();
  endtask

  task automatic test_back_to_back();
    start_run(12, 1'b1);
    for (int s = 0; s < 12; s++) send_sample(0, 0);
    end_run();
    for (int c = 0; c < 3; c++) begin
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL held_start got=%0d exp=0", state_o); end
      step();
    end
    ap_start = 1'b0;
    step();
  endtask

  task automatic test_zero_length();
    start_run(0, 1'b0);
    end_run();
  endtask

  task automatic test_reset_mid_mac();
    start_run(2, 1'b0);
    ss_tvalid = 1'b1; ss_tdata = $urandom;
    step();
    ss_tvalid = 1'b0;
    repeat (4) step();
    checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL pre_rst_state got=%0d exp=2", state_o); end
    axis_rst_n = 1'b0;
    step();
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL mid_rst_state got=%0d exp=0", state_o); end
    checks++; if (mac_en !== 1'b0) begin failures++; $display("FAIL mid_rst_mac_en got=%0h exp=0", mac_en); end
    checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL mid_rst_idle got=%0h exp=1", ap_idle); end
    axis_rst_n = 1'b1;
    step();
  endtask

  task automatic test_random_runs();
    int len;
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 5);
      start_run(len, 1'($urandom_range(0, 1)));
      for (int s = 0; s < len; s++) send_sample($urandom_range(0, 4), $urandom_range(0, 3));
      end_run();
      ap_start = 1'b0;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_run_backpressure();
    test_back_to_back();
    test_zero_length();
    test_reset_mid_mac();
    test_random_runs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
